// File: rtl/traffic_lamp_monitor_pkg.sv
// Shared types and timing constants for the intersection lamp-bus safety monitor.
package traffic_pkg;

    localparam int T_GREEN  = 10;
    localparam int T_YELLOW = 3;
    localparam int T_SLACK  = 1;
    localparam int T_FLASH  = 4;

    typedef enum logic [1:0] {
        C_RED    = 2'd0,
        C_YELLOW = 2'd1,
        C_GREEN  = 2'd2,
        C_BAD    = 2'd3
    } colour_t;

    typedef enum logic [2:0] {
        F_NONE         = 3'd0,
        F_LAMP_INVALID = 3'd1,
        F_CONFLICT     = 3'd2,
        F_SEQ_ERR      = 3'd3,
        F_YELLOW_TIME  = 3'd4,
        F_SHORT_GREEN  = 3'd5,
        F_STUCK_GREEN  = 3'd6
    } fault_code_t;

    typedef enum logic [1:0] {
        M_ARM   = 2'd0,
        M_RUN   = 2'd1,
        M_FAULT = 2'd2
    } mon_state_t;

    // A lamp group is only meaningful when exactly one of its three lines is lit.
    function automatic colour_t decode_lamp(input logic red, input logic yellow, input logic green);
        colour_t c;
        case ({red, yellow, green})
            3'b100:  c = C_RED;
            3'b010:  c = C_YELLOW;
            3'b001:  c = C_GREEN;
            default: c = C_BAD;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/traffic_approach_checker.sv
// Per-approach tracker: decodes the lamp lines, remembers the previous colour and how long
// it has been held, and raises the sequence/timing flags the monitor priority-encodes.
module traffic_approach_checker
    import traffic_pkg::*;
#(
    parameter int T_GREEN_P  = T_GREEN,
    parameter int T_YELLOW_P = T_YELLOW,
    parameter int T_SLACK_P  = T_SLACK
) (
    input  logic clk,
    input  logic rst,
    input  logic arm,
    input  logic lamp_red,
    input  logic lamp_yellow,
    input  logic lamp_green,
    output logic bad,
    output logic non_red,
    output logic seq_err,
    output logic yellow_time,
    output logic short_green,
    output logic stuck_green
);

    localparam int DWELL_W = $clog2(T_GREEN_P + T_SLACK_P + 2);
    localparam logic [DWELL_W-1:0] YELLOW_LIM = DWELL_W'(T_YELLOW_P);
    localparam logic [DWELL_W-1:0] GREEN_MIN  = DWELL_W'(T_GREEN_P);
    localparam logic [DWELL_W-1:0] GREEN_MAX  = DWELL_W'(T_GREEN_P + T_SLACK_P);
    localparam logic [DWELL_W-1:0] DWELL_SAT  = '1;

    colour_t            cur;
    colour_t            prev_q, prev_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               measured_q, measured_d;
    logic               changed;
    logic               legal_step;

    assign cur     = decode_lamp(lamp_red, lamp_yellow, lamp_green);
    assign bad     = (cur == C_BAD);
    assign non_red = (cur != C_RED);

    // Compare this cycle's colour with the registered one; dwell_q counts cycles already held.
    always_comb begin
        changed     = (cur != prev_q);
        legal_step  = ((prev_q == C_GREEN)  && (cur == C_YELLOW)) ||
                      ((prev_q == C_YELLOW) && (cur == C_RED))    ||
                      ((prev_q == C_RED)    && (cur == C_GREEN));
        seq_err     = changed && !legal_step;
        yellow_time = (prev_q == C_YELLOW) &&
                      (((cur == C_YELLOW) && (dwell_q >= YELLOW_LIM)) ||
                       ((cur != C_YELLOW) && measured_q && (dwell_q != YELLOW_LIM)));
        short_green = (prev_q == C_GREEN) && (cur != C_GREEN) && measured_q && (dwell_q < GREEN_MIN);
        stuck_green = (prev_q == C_GREEN) && (cur == C_GREEN) && (dwell_q >= GREEN_MAX);
    end

    // Arming restarts tracking without history; a colour change opens a measured segment.
    always_comb begin
        prev_d     = prev_q;
        dwell_d    = dwell_q;
        measured_d = measured_q;
        if (arm) begin
            prev_d     = cur;
            dwell_d    = DWELL_W'(1);
            measured_d = 1'b0;
        end else if (changed) begin
            prev_d     = cur;
            dwell_d    = DWELL_W'(1);
            measured_d = 1'b1;
        end else if (dwell_q != DWELL_SAT) begin
            dwell_d    = dwell_q + DWELL_W'(1);
        end
    end

    // Tracking registers; reset assumes an all-red intersection with nothing measured.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q     <= C_RED;
            dwell_q    <= '0;
            measured_q <= 1'b0;
        end else begin
            prev_q     <= prev_d;
            dwell_q    <= dwell_d;
            measured_q <= measured_d;
        end
    end

endmodule

// File: rtl/traffic_lamp_monitor.sv
// Independent lamp-bus safety monitor: latches the first violation and flashes red until cleared.
module traffic_lamp_monitor
    import traffic_pkg::*;
#(
    parameter int T_GREEN_P  = T_GREEN,
    parameter int T_YELLOW_P = T_YELLOW,
    parameter int T_SLACK_P  = T_SLACK,
    parameter int T_FLASH_P  = T_FLASH
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       NS_red,
    input  logic       NS_yellow,
    input  logic       NS_green,
    input  logic       EW_red,
    input  logic       EW_yellow,
    input  logic       EW_green,
    input  logic       fault_clr,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic       flash_red
);

    localparam int FLASH_W = (T_FLASH_P > 1) ? $clog2(T_FLASH_P) : 1;
    localparam logic [FLASH_W-1:0] FLASH_LAST = FLASH_W'(T_FLASH_P - 1);

    mon_state_t         state_q, state_d;
    fault_code_t        code_q, code_d, violation;
    logic               flash_q, flash_d;
    logic [FLASH_W-1:0] flash_cnt_q, flash_cnt_d;
    logic               arm;

    logic ns_bad, ns_non_red, ns_seq, ns_yel, ns_short, ns_stuck;
    logic ew_bad, ew_non_red, ew_seq, ew_yel, ew_short, ew_stuck;

    assign arm = (state_q == M_ARM);

    traffic_approach_checker #(
        .T_GREEN_P  (T_GREEN_P),
        .T_YELLOW_P (T_YELLOW_P),
        .T_SLACK_P  (T_SLACK_P)
    ) u_ns (
        .clk         (clk),
        .rst         (rst),
        .arm         (arm),
        .lamp_red    (NS_red),
        .lamp_yellow (NS_yellow),
        .lamp_green  (NS_green),
        .bad         (ns_bad),
        .non_red     (ns_non_red),
        .seq_err     (ns_seq),
        .yellow_time (ns_yel),
        .short_green (ns_short),
        .stuck_green (ns_stuck)
    );

    traffic_approach_checker #(
        .T_GREEN_P  (T_GREEN_P),
        .T_YELLOW_P (T_YELLOW_P),
        .T_SLACK_P  (T_SLACK_P)
    ) u_ew (
        .clk         (clk),
        .rst         (rst),
        .arm         (arm),
        .lamp_red    (EW_red),
        .lamp_yellow (EW_yellow),
        .lamp_green  (EW_green),
        .bad         (ew_bad),
        .non_red     (ew_non_red),
        .seq_err     (ew_seq),
        .yellow_time (ew_yel),
        .short_green (ew_short),
        .stuck_green (ew_stuck)
    );

    // Pick the single most severe violation seen on either approach this cycle.
    always_comb begin
        violation = F_NONE;
        if (ns_bad || ew_bad)               violation = F_LAMP_INVALID;
        else if (ns_non_red && ew_non_red)  violation = F_CONFLICT;
        else if (ns_seq || ew_seq)          violation = F_SEQ_ERR;
        else if (ns_yel || ew_yel)          violation = F_YELLOW_TIME;
        else if (ns_short || ew_short)      violation = F_SHORT_GREEN;
        else if (ns_stuck || ew_stuck)      violation = F_STUCK_GREEN;
    end

    // Monitor FSM: arm for one sample, run checks, then hold the fault and flash until cleared.
    always_comb begin
        state_d     = state_q;
        code_d      = code_q;
        flash_d     = flash_q;
        flash_cnt_d = flash_cnt_q;
        case (state_q)
            M_ARM: begin
                state_d = M_RUN;
            end
            M_RUN: begin
                if (violation != F_NONE) begin
                    state_d     = M_FAULT;
                    code_d      = violation;
                    flash_d     = 1'b1;
                    flash_cnt_d = '0;
                end
            end
            M_FAULT: begin
                if (fault_clr) begin
                    state_d     = M_ARM;
                    code_d      = F_NONE;
                    flash_d     = 1'b0;
                    flash_cnt_d = '0;
                end else if (flash_cnt_q == FLASH_LAST) begin
                    flash_d     = ~flash_q;
                    flash_cnt_d = '0;
                end else begin
                    flash_cnt_d = flash_cnt_q + FLASH_W'(1);
                end
            end
            default: begin
                state_d     = M_ARM;
                code_d      = F_NONE;
                flash_d     = 1'b0;
                flash_cnt_d = '0;
            end
        endcase
    end

    // Monitor state registers; reset overrides a pending clear or violation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= M_ARM;
            code_q      <= F_NONE;
            flash_q     <= 1'b0;
            flash_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            code_q      <= code_d;
            flash_q     <= flash_d;
            flash_cnt_q <= flash_cnt_d;
        end
    end

    assign fault      = (state_q == M_FAULT);
    assign fault_code = code_q;
    assign flash_red  = flash_q;

endmodule

// File: tb/tb_traffic_lamp_monitor.sv
// Self-checking bench for traffic_lamp_monitor: directed scenarios plus randomized lamp traffic,
// each cycle compared against a cycle-level behavioural model of the monitor rules.
module tb_traffic_lamp_monitor;

    localparam int T_GREEN  = 10;
    localparam int T_YELLOW = 3;
    localparam int T_SLACK  = 1;
    localparam int T_FLASH  = 4;

    localparam int RED = 0, YEL = 1, GRN = 2, BAD = 3;
    localparam int ST_ARM = 0, ST_RUN = 1, ST_FAULT = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       NS_red = 1'b1, NS_yellow = 1'b0, NS_green = 1'b0;
    logic       EW_red = 1'b1, EW_yellow = 1'b0, EW_green = 1'b0;
    logic       fault_clr = 1'b0;
    logic       fault;
    logic [2:0] fault_code;
    logic       flash_red;

    int assert_count = 0;
    int fail_count   = 0;

    // Behavioural model state
    int m_state = ST_ARM;
    int m_code  = 0;
    int m_fault_cycles = 0;
    int m_prev [2] = '{RED, RED};
    int m_len  [2] = '{0, 0};
    int m_meas [2] = '{0, 0};

    always #5 clk = ~clk;

    traffic_lamp_monitor dut (
        .clk        (clk),
        .rst        (rst),
        .NS_red     (NS_red),
        .NS_yellow  (NS_yellow),
        .NS_green   (NS_green),
        .EW_red     (EW_red),
        .EW_yellow  (EW_yellow),
        .EW_green   (EW_green),
        .fault_clr  (fault_clr),
        .fault      (fault),
        .fault_code (fault_code),
        .flash_red  (flash_red)
    );

    function automatic int colour_of(input logic [2:0] ryg);
        if (ryg == 3'b100) return RED;
        if (ryg == 3'b010) return YEL;
        if (ryg == 3'b001) return GRN;
        return BAD;
    endfunction

    // Well-behaved controller: NS green 10, NS yellow 3, EW green 10, EW yellow 3, repeat.
    function automatic logic [5:0] legal_lines(input int t);
        int p;
        p = t % 26;
        if (p < 10) return 6'b001_100;
        if (p < 13) return 6'b010_100;
        if (p < 23) return 6'b100_001;
        return 6'b100_010;
    endfunction

    // Advance the model by one clock edge given the inputs sampled at that edge.
    task automatic model_step(input logic [5:0] lines, input logic clr, input logic rs);
        int cur [2];
        int code;
        bit any_seq, any_yel, any_short, any_stuck;
        cur[0] = colour_of(lines[5:3]);
        cur[1] = colour_of(lines[2:0]);
        if (rs) begin
            m_state = ST_ARM;
            m_code  = 0;
            m_fault_cycles = 0;
            for (int a = 0; a < 2; a++) begin
                m_prev[a] = RED; m_len[a] = 0; m_meas[a] = 0;
            end
            return;
        end
        case (m_state)
            ST_ARM: begin
                for (int a = 0; a < 2; a++) begin
                    m_prev[a] = cur[a]; m_len[a] = 1; m_meas[a] = 0;
                end
                m_state = ST_RUN;
            end
            ST_RUN: begin
                any_seq = 0; any_yel = 0; any_short = 0; any_stuck = 0;
                for (int a = 0; a < 2; a++) begin
                    int p, c, held;
                    p = m_prev[a]; c = cur[a]; held = m_len[a];
                    if (c != p && !((p == GRN && c == YEL) || (p == YEL && c == RED) || (p == RED && c == GRN)))
                        any_seq = 1;
                    if (p == YEL && c == YEL && held + 1 > T_YELLOW) any_yel = 1;
                    if (p == YEL && c != YEL && m_meas[a] != 0 && held != T_YELLOW) any_yel = 1;
                    if (p == GRN && c != GRN && m_meas[a] != 0 && held < T_GREEN) any_short = 1;
                    if (p == GRN && c == GRN && held + 1 > T_GREEN + T_SLACK) any_stuck = 1;
                    if (c != p) begin
                        m_len[a] = 1; m_meas[a] = 1;
                    end else begin
                        m_len[a] = held + 1;
                    end
                    m_prev[a] = c;
                end
                code = 0;
                if (cur[0] == BAD || cur[1] == BAD) code = 1;
                else if (cur[0] != RED && cur[1] != RED) code = 2;
                else if (any_seq)   code = 3;
                else if (any_yel)   code = 4;
                else if (any_short) code = 5;
                else if (any_stuck) code = 6;
                if (code != 0) begin
                    m_state = ST_FAULT;
                    m_code  = code;
                    m_fault_cycles = 0;
                end
            end
            default: begin
                if (clr) begin
                    m_state = ST_ARM;
                    m_code  = 0;
                end else begin
                    m_fault_cycles++;
                end
            end
        endcase
    endtask

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert_count++;
        assert (obs === exp) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic checkOutput();
        int e_fault, e_code, e_flash;
        e_fault = (m_state == ST_FAULT) ? 1 : 0;
        e_code  = (m_state == ST_FAULT) ? m_code : 0;
        e_flash = (m_state == ST_FAULT && ((m_fault_cycles / T_FLASH) % 2) == 0) ? 1 : 0;
        checkValue("fault",      32'(fault),      32'(e_fault));
        checkValue("fault_code", 32'(fault_code), 32'(e_code));
        checkValue("flash_red",  32'(flash_red),  32'(e_flash));
    endtask

    task automatic applyStimulus(input logic [5:0] lines, input logic clr, input logic rs);
        {NS_red, NS_yellow, NS_green, EW_red, EW_yellow, EW_green} = lines;
        fault_clr = clr;
        rst       = rs;
        @(posedge clk);
        model_step(lines, clr, rs);
        #1;
        checkOutput();
    endtask

    task automatic doReset();
        applyStimulus(legal_lines(0), 1'b0, 1'b1);
        applyStimulus(legal_lines(0), 1'b0, 1'b1);
    endtask

    task automatic runLegal(input int start, input int n);
        for (int t = start; t < start + n; t++) applyStimulus(legal_lines(t), 1'b0, 1'b0);
    endtask

    initial begin
        int offset, t, flash_seen;
        logic [5:0] lines;

        $display("[TB] reset state");
        doReset();
        checkValue("reset_fault", 32'(fault), 32'd0);
        checkValue("reset_code",  32'(fault_code), 32'd0);

        $display("[TB] legal traffic, 300 cycles");
        offset = $urandom_range(0, 25);
        flash_seen = 0;
        for (int i = 0; i < 300; i++) begin
            applyStimulus(legal_lines(offset + i), 1'b0, 1'b0);
            if (flash_red !== 1'b0 || fault !== 1'b0) flash_seen++;
        end
        checkValue("legal_quiet", 32'(flash_seen), 32'd0);

        $display("[TB] conflict at cycle 50");
        doReset();
        runLegal(0, 50);
        applyStimulus(6'b001_001, 1'b0, 1'b0);
        checkValue("conflict_fault", 32'(fault), 32'd1);
        checkValue("conflict_code",  32'(fault_code), 32'd2);
        checkValue("flash_0", 32'(flash_red), 32'd1);
        for (int k = 1; k < 10; k++) begin
            applyStimulus(6'b000_000, 1'b0, 1'b0);
            checkValue("flash_pattern", 32'(flash_red), (k % 8 < 4) ? 32'd1 : 32'd0);
        end
        checkValue("code_held", 32'(fault_code), 32'd2);

        $display("[TB] fault_clr and clean re-arm");
        applyStimulus(legal_lines(0), 1'b1, 1'b0);
        checkValue("clr_fault", 32'(fault), 32'd0);
        checkValue("clr_flash", 32'(flash_red), 32'd0);
        runLegal(0, 60);
        checkValue("rearm_quiet", 32'(fault), 32'd0);
        applyStimulus(6'b001_001, 1'b1, 1'b0);
        checkValue("clr_vs_violation", 32'(fault), 32'd1);
        applyStimulus(legal_lines(0), 1'b1, 1'b1);
        checkValue("rst_fault", 32'(fault), 32'd0);
        checkValue("rst_code",  32'(fault_code), 32'd0);
        checkValue("rst_flash", 32'(flash_red), 32'd0);

        $display("[TB] yellow held 4 after measured green");
        doReset();
        runLegal(0, 39);
        checkValue("yellow_pre", 32'(fault), 32'd0);
        applyStimulus(6'b010_100, 1'b0, 1'b0);
        checkValue("yellow_code", 32'(fault_code), 32'd4);

        $display("[TB] green to red directly");
        doReset();
        runLegal(0, 5);
        applyStimulus(6'b100_100, 1'b0, 1'b0);
        checkValue("seq_code", 32'(fault_code), 32'd3);

        $display("[TB] NS all dark");
        doReset();
        runLegal(0, 5);
        applyStimulus(6'b000_100, 1'b0, 1'b0);
        checkValue("dark_code", 32'(fault_code), 32'd1);

        $display("[TB] NS red+green");
        doReset();
        runLegal(0, 5);
        applyStimulus(6'b101_100, 1'b0, 1'b0);
        checkValue("double_code", 32'(fault_code), 32'd1);

        $display("[TB] EW green held 12");
        doReset();
        runLegal(0, 23);
        applyStimulus(6'b100_001, 1'b0, 1'b0);
        checkValue("green11_ok", 32'(fault), 32'd0);
        applyStimulus(6'b100_001, 1'b0, 1'b0);
        checkValue("stuck_code", 32'(fault_code), 32'd6);

        $display("[TB] EW green exits at 9");
        doReset();
        runLegal(0, 22);
        applyStimulus(6'b100_010, 1'b0, 1'b0);
        checkValue("short_code", 32'(fault_code), 32'd5);

        $display("[TB] randomized traffic with corruptions");
        doReset();
        t = $urandom_range(0, 25);
        for (int i = 0; i < 2000; i++) begin
            int r;
            r = $urandom_range(0, 29);
            if (r == 0)      t = t;
            else if (r == 1) t = t + 2;
            else             t = t + 1;
            lines = legal_lines(t);
            if ($urandom_range(0, 39) == 0) lines = lines ^ (6'b000001 << $urandom_range(0, 5));
            applyStimulus(lines, ($urandom_range(0, 15) == 0), ($urandom_range(0, 299) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
